req_queue: RTL and testbench

- Host-side request buffer directly upstream of the DDR5 processing unit.
- Accepts single-address read/write requests from the host and sorts them into separate read and write FIFOs.
- Presents each queue head to the processing unit as rd_adrs/wr_adrs, with empty flags rd_mt/wr_mt.
- The processing unit pops a queue with rd_en/wr_en.
- Enforces read-after-write ordering: a read whose address matches a pending write is stalled until that write drains.

---
 rtl/req_queue.sv | 107 ++++++++++
 tb/tb_req_queue.sv | 212 +++++++++++++++++++++
 2 files changed

// File: rtl/req_queue.sv
// Host request buffer ahead of the DDR5 processing unit: splits requests into
// read and write FIFOs and holds reads that hit a pending write address.
module req_queue #(
    parameter int ADRS_W = 32,
    parameter int DEPTH  = 8,
    parameter int AW     = 3,
    parameter int WM_HI  = 6,
    parameter bit HAZ_EN = 1'b1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              host_valid,
    input  logic              host_rw,
    input  logic [ADRS_W-1:0] host_adrs,
    output logic              host_ready,
    input  logic              rd_en,
    input  logic              wr_en,
    output logic [ADRS_W-1:0] rd_adrs,
    output logic [ADRS_W-1:0] wr_adrs,
    output logic              rd_mt,
    output logic              wr_mt,
    output logic              rd_full,
    output logic              wr_full,
    output logic [AW:0]       rd_cnt,
    output logic [AW:0]       wr_cnt,
    output logic              wr_urgent,
    output logic              pop_err
);
    localparam int RD = 0;
    localparam int WR = 1;
    localparam int CW = AW + 1;

    logic [ADRS_W-1:0]     mem_q [2][DEPTH];
    logic [1:0][AW-1:0]    head_q, head_d, tail_q, tail_d;
    logic [1:0][CW-1:0]    cnt_q, cnt_d;
    logic [1:0]            push, pop, do_pop, mt, full;
    logic                  pop_err_q, pop_err_d;
    logic                  hazard;

    assign pop  = {wr_en, rd_en};
    assign mt   = {cnt_q[WR] == '0, cnt_q[RD] == '0};
    assign full = {cnt_q[WR] == CW'(DEPTH), cnt_q[RD] == CW'(DEPTH)};

    // A read must wait while its address sits anywhere in the write queue.
    always_comb begin
        hazard = 1'b0;
        for (int i = 0; i < DEPTH; i++) begin
            if (HAZ_EN && (mem_q[WR][i] == host_adrs) &&
                ({1'b0, AW'(i) - head_q[WR]} < cnt_q[WR]))
                hazard = 1'b1;
        end
    end

    always_comb begin
        host_ready = host_rw ? !full[WR] : (!full[RD] && !hazard);
        push[RD]   = host_valid && host_ready && !host_rw;
        push[WR]   = host_valid && host_ready && host_rw;
    end

    always_comb begin
        head_d    = head_q;
        tail_d    = tail_q;
        cnt_d     = cnt_q;
        do_pop    = '0;
        pop_err_d = 1'b0;
        for (int q = 0; q < 2; q++) begin
            do_pop[q] = pop[q] && !mt[q];
            head_d[q] = head_q[q] + AW'(do_pop[q]);
            tail_d[q] = tail_q[q] + AW'(push[q]);
            cnt_d[q]  = cnt_q[q] + CW'(push[q]) - CW'(do_pop[q]);
            pop_err_d = pop_err_d | (pop[q] && mt[q]);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            head_q    <= '0;
            tail_q    <= '0;
            cnt_q     <= '0;
            pop_err_q <= 1'b0;
        end else begin
            head_q    <= head_d;
            tail_q    <= tail_d;
            cnt_q     <= cnt_d;
            pop_err_q <= pop_err_d;
        end
    end

    // Storage needs no reset: occupancy gates every use of an entry.
    always_ff @(posedge clk) begin
        for (int q = 0; q < 2; q++) begin
            if (!rst && push[q])
                mem_q[q][tail_q[q]] <= host_adrs;
        end
    end

    assign rd_adrs   = mt[RD] ? '0 : mem_q[RD][head_q[RD]];
    assign wr_adrs   = mt[WR] ? '0 : mem_q[WR][head_q[WR]];
    assign rd_mt     = mt[RD];
    assign wr_mt     = mt[WR];
    assign rd_full   = full[RD];
    assign wr_full   = full[WR];
    assign rd_cnt    = cnt_q[RD];
    assign wr_cnt    = cnt_q[WR];
    assign wr_urgent = cnt_q[WR] >= CW'(WM_HI);
    assign pop_err   = pop_err_q;
endmodule

// File: tb/tb_req_queue.sv
// Directed bench for req_queue: address scoreboards per queue, plus a second
// instance with the read-after-write stall disabled.
module tb_req_queue;
    logic        clk = 1'b0;
    logic        rst, host_valid, host_rw, rd_en, wr_en;
    logic [31:0] host_adrs;
    logic        host_ready, rd_mt, wr_mt, rd_full, wr_full, wr_urgent, pop_err;
    logic [31:0] rd_adrs, wr_adrs;
    logic [3:0]  rd_cnt, wr_cnt;
    logic        nh_ready, nh_rd_mt, nh_wr_mt, nh_rd_full, nh_wr_full, nh_urgent, nh_pop_err;
    logic [31:0] nh_rd_adrs, nh_wr_adrs;
    logic [3:0]  nh_rd_cnt, nh_wr_cnt;

    int n_cmp = 0;
    int n_err = 0;
    logic [31:0] rd_sb[$];
    logic [31:0] wr_sb[$];

    req_queue dut (
        .clk(clk), .rst(rst), .host_valid(host_valid), .host_rw(host_rw),
        .host_adrs(host_adrs), .host_ready(host_ready), .rd_en(rd_en), .wr_en(wr_en),
        .rd_adrs(rd_adrs), .wr_adrs(wr_adrs), .rd_mt(rd_mt), .wr_mt(wr_mt),
        .rd_full(rd_full), .wr_full(wr_full), .rd_cnt(rd_cnt), .wr_cnt(wr_cnt),
        .wr_urgent(wr_urgent), .pop_err(pop_err)
    );

    req_queue #(.HAZ_EN(1'b0)) u_nh (
        .clk(clk), .rst(rst), .host_valid(host_valid), .host_rw(host_rw),
        .host_adrs(host_adrs), .host_ready(nh_ready), .rd_en(rd_en), .wr_en(wr_en),
        .rd_adrs(nh_rd_adrs), .wr_adrs(nh_wr_adrs), .rd_mt(nh_rd_mt), .wr_mt(nh_wr_mt),
        .rd_full(nh_rd_full), .wr_full(nh_wr_full), .rd_cnt(nh_rd_cnt), .wr_cnt(nh_wr_cnt),
        .wr_urgent(nh_urgent), .pop_err(nh_pop_err)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_rst();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        rd_sb.delete();
        wr_sb.delete();
    endtask

    task automatic push(input logic rw, input logic [31:0] a);
        host_valid = 1'b1;
        host_rw    = rw;
        host_adrs  = a;
        #1 chk("push_ready", host_ready, 1);
        if (rw) wr_sb.push_back(a);
        else    rd_sb.push_back(a);
        tick();
        host_valid = 1'b0;
    endtask

    task automatic pop_rd();
        logic [31:0] e;
        e = rd_sb.pop_front();
        chk("rd_head", rd_adrs, e);
        rd_en = 1'b1;
        tick();
        rd_en = 1'b0;
    endtask

    task automatic pop_wr();
        logic [31:0] e;
        e = wr_sb.pop_front();
        chk("wr_head", wr_adrs, e);
        wr_en = 1'b1;
        tick();
        wr_en = 1'b0;
    endtask

    initial begin
        rst = 1'b1; host_valid = 1'b0; host_rw = 1'b0; host_adrs = '0;
        rd_en = 1'b0; wr_en = 1'b0;
        tick(); tick();
        rst = 1'b0;
        chk("rst_rd_mt", rd_mt, 1);
        chk("rst_wr_mt", wr_mt, 1);
        chk("rst_rd_full", rd_full, 0);
        chk("rst_wr_full", wr_full, 0);
        chk("rst_urgent", wr_urgent, 0);
        chk("rst_pop_err", pop_err, 0);
        chk("rst_rd_adrs", rd_adrs, 0);
        chk("rst_wr_adrs", wr_adrs, 0);

        // Three reads then drain
        chk("pre_rd_mt", rd_mt, 1);
        push(1'b0, 32'h100);
        chk("rd_mt_fall", rd_mt, 0);
        push(1'b0, 32'h104);
        push(1'b0, 32'h108);
        chk("rd_cnt3", rd_cnt, 3);
        repeat (3) pop_rd();
        chk("rd_drained_adrs", rd_adrs, 0);
        chk("rd_drained_mt", rd_mt, 1);
        chk("rd_drained_cnt", rd_cnt, 0);

        // Fill write queue, watermark, full, wrap
        for (int i = 0; i < 8; i++) begin
            push(1'b1, 32'h1000 + 32'(i * 4));
            chk("wr_urgent", wr_urgent, (i + 1 >= 6) ? 1 : 0);
        end
        chk("wr_full", wr_full, 1);
        chk("wr_cnt8", wr_cnt, 8);
        host_valid = 1'b1; host_rw = 1'b1; host_adrs = 32'hdead;
        #1 chk("full_ready", host_ready, 0);
        tick();
        host_valid = 1'b0;
        chk("full_no_push", wr_cnt, 8);
        pop_wr();
        chk("wr_cnt7", wr_cnt, 7);
        push(1'b1, 32'h2000);
        chk("wr_cnt_refill", wr_cnt, 8);
        repeat (8) pop_wr();
        chk("wr_drained_mt", wr_mt, 1);

        // Read-after-write hazard on a non-head entry
        do_rst();
        push(1'b1, 32'h200);
        push(1'b1, 32'h300);
        host_valid = 1'b1; host_rw = 1'b0; host_adrs = 32'h300;
        #1 chk("haz_ready", host_ready, 0);
        chk("nohaz_ready", nh_ready, 1);
        tick();
        chk("nohaz_accept", nh_rd_cnt, 1);
        chk("haz_hold_cnt", rd_cnt, 0);
        pop_wr();
        chk("haz_still", host_ready, 0);
        pop_wr();
        chk("haz_release", host_ready, 1);
        rd_sb.push_back(32'h300);
        tick();
        host_valid = 1'b0;
        chk("haz_accepted", rd_cnt, 1);
        pop_rd();

        // Simultaneous push/pop at occupancy 2 across the wrap
        do_rst();
        push(1'b0, 32'h400);
        push(1'b0, 32'h404);
        for (int i = 0; i < 20; i++) begin
            logic [31:0] e;
            e = rd_sb.pop_front();
            chk("pp_head", rd_adrs, e);
            host_valid = 1'b1; host_rw = 1'b0; host_adrs = 32'h500 + 32'(i);
            rd_en = 1'b1;
            rd_sb.push_back(32'h500 + 32'(i));
            tick();
            host_valid = 1'b0; rd_en = 1'b0;
            chk("pp_cnt", rd_cnt, 2);
        end
        repeat (2) pop_rd();

        // Pop on empty, alone and with a same-cycle push
        do_rst();
        rd_en = 1'b1;
        tick();
        rd_en = 1'b0;
        chk("perr_pulse", pop_err, 1);
        chk("perr_rd_cnt", rd_cnt, 0);
        chk("perr_wr_cnt", wr_cnt, 0);
        tick();
        chk("perr_clear", pop_err, 0);
        host_valid = 1'b1; host_rw = 1'b0; host_adrs = 32'h700; rd_en = 1'b1;
        rd_sb.push_back(32'h700);
        tick();
        host_valid = 1'b0; rd_en = 1'b0;
        chk("perr_push_pulse", pop_err, 1);
        chk("perr_push_cnt", rd_cnt, 1);
        tick();
        chk("perr_push_clear", pop_err, 0);
        pop_rd();

        // Reset mid-operation with a push in the reset cycle
        do_rst();
        for (int i = 0; i < 4; i++) push(1'b0, 32'h10 + 32'(i * 4));
        for (int i = 0; i < 4; i++) push(1'b1, 32'h20 + 32'(i * 4));
        host_valid = 1'b1; host_rw = 1'b0; host_adrs = 32'h99; rd_en = 1'b1; wr_en = 1'b1;
        do_rst();
        host_valid = 1'b0; rd_en = 1'b0; wr_en = 1'b0;
        chk("mid_rd_mt", rd_mt, 1);
        chk("mid_wr_mt", wr_mt, 1);
        chk("mid_rd_cnt", rd_cnt, 0);
        chk("mid_wr_cnt", wr_cnt, 0);
        chk("mid_rd_adrs", rd_adrs, 0);
        chk("mid_wr_adrs", wr_adrs, 0);
        push(1'b0, 32'h44);
        push(1'b1, 32'h48);
        pop_rd();
        pop_wr();
        chk("post_rd_mt", rd_mt, 1);
        chk("post_wr_mt", wr_mt, 1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
